// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter: port states,
// access kinds, and the response routing tag.
package mem_arb_pkg;

   localparam int MAX_REQ = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_DATA = 1'b1
   } port_state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // Index width for n items, never less than one bit.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

   localparam int TAG_W = clog2(MAX_REQ);

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] idx;
   } tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Round-robin picker: selects up to two requesters in scan order starting at rr_ptr.
// The second pick must be compatible with the first, as described by pair_ok.
module rr_pick2
   import mem_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]          elig,
   input  logic [N-1:0][N-1:0]   pair_ok,
   input  logic [IW-1:0]         rr_ptr,
   output logic [IW-1:0]         idx0,
   output logic                  vld0,
   output logic [IW-1:0]         idx1,
   output logic                  vld1
);

   logic [IW-1:0] cand;

   always_comb begin
      int sum;
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      vld0 = 1'b0;
      idx0 = '0;
      vld1 = 1'b0;
      idx1 = '0;
      cand = '0;
      sum  = 0;
      for (int k = 0; k < N; k++) begin
         sum = int'(rr_ptr) + k;
         if (sum >= N) sum = sum - N;
         cand = IW'(sum);
         if (!vld0) begin
            if (elig[cand]) begin
               vld0 = 1'b1;
               idx0 = cand;
            end
         end else if (!vld1 && pair_ok[idx0][cand]) begin
            vld1 = 1'b1;
            idx1 = cand;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the two ports of a dual-port synchronous RAM among NUM_REQ requesters,
// with round-robin grants, collision blocking and fixed two-cycle read responses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 290,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           reset_N,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [NUM_REQ*DATA_WIDTH-1:0]  rsp_rdata,
   output logic [ADDR_WIDTH-1:0]          ram_address_0,
   output logic [ADDR_WIDTH-1:0]          ram_address_1,
   output logic [DATA_WIDTH-1:0]          ram_data_in_0,
   output logic [DATA_WIDTH-1:0]          ram_data_in_1,
   output logic                           ram_cs_0,
   output logic                           ram_cs_1,
   output logic                           ram_we_0,
   output logic                           ram_we_1,
   output logic                           ram_oe_0,
   output logic                           ram_oe_1,
   input  logic [DATA_WIDTH-1:0]          ram_data_out_0,
   input  logic [DATA_WIDTH-1:0]          ram_data_out_1
);

   localparam int IW = clog2(NUM_REQ);

   logic [ADDR_WIDTH-1:0] addr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   port_state_t           state_q     [2];
   port_state_t           state_d     [2];
   logic [ADDR_WIDTH-1:0] hold_addr_q [2];
   logic [IW-1:0]         rr_ptr_q;

   function automatic logic port_can(input port_state_t s, input logic we);
      return (s == IDLE) || !we;
   endfunction

   logic [NUM_REQ-1:0]              elig;
   logic [NUM_REQ-1:0]              first_port;
   logic [NUM_REQ-1:0][NUM_REQ-1:0] pair_ok;

   // Grants are suppressed while reset is held so every output sits at zero.
   always_comb begin
      elig       = '0;
      first_port = '0;
      pair_ok    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         first_port[i] = !port_can(state_q[0], req_we[i]);
         elig[i] = reset_N && req_valid[i] &&
                   (port_can(state_q[0], req_we[i]) || port_can(state_q[1], req_we[i]));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            pair_ok[i][j] = (i != j) && req_valid[j] &&
                            port_can(first_port[i] ? state_q[0] : state_q[1], req_we[j]) &&
                            !((addr[i] == addr[j]) && (req_we[i] || req_we[j]));
         end
      end
   end

   logic [IW-1:0] idx0, idx1;
   logic          vld0, vld1;

   rr_pick2 #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .elig    (elig),
      .pair_ok (pair_ok),
      .rr_ptr  (rr_ptr_q),
      .idx0    (idx0),
      .vld0    (vld0),
      .idx1    (idx1),
      .vld1    (vld1)
   );

   logic [1:0]    port_gnt;
   logic [IW-1:0] port_idx [2];
   op_t           port_op  [2];

   always_comb begin
      port_gnt    = '0;
      port_idx[0] = '0;
      port_idx[1] = '0;
      if (vld0) begin
         if (first_port[idx0]) begin
            port_gnt[1] = 1'b1;
            port_idx[1] = idx0;
         end else begin
            port_gnt[0] = 1'b1;
            port_idx[0] = idx0;
         end
         if (vld1) begin
            if (first_port[idx0]) begin
               port_gnt[0] = 1'b1;
               port_idx[0] = idx1;
            end else begin
               port_gnt[1] = 1'b1;
               port_idx[1] = idx1;
            end
         end
      end
      for (int p = 0; p < 2; p++) begin
         port_op[p] = req_we[port_idx[p]] ? OP_WR : OP_RD;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (vld0 && (idx0 == IW'(i))) || (vld1 && (idx1 == IW'(i)));
      end
   end

   logic [IW-1:0] last_idx, rr_next;

   always_comb begin
      last_idx = vld1 ? idx1 : idx0;
      rr_next  = (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + IW'(1);
   end

   // Port FSM: state register.
   always_ff @(posedge clk or negedge reset_N) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (!reset_N) begin
         for (int p = 0; p < 2; p++) begin
            state_q[p]     <= IDLE;
            hold_addr_q[p] <= '0;
         end
         rr_ptr_q <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            state_q[p] <= state_d[p];
            if (port_gnt[p] && (port_op[p] == OP_RD)) hold_addr_q[p] <= addr[port_idx[p]];
         end
         if (vld0) rr_ptr_q <= rr_next;
      end
   end

   // Port FSM: next state. A port owes the RAM a read-enable in the cycle after any read grant.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         state_d[p] = (port_gnt[p] && (port_op[p] == OP_RD)) ? RD_DATA : IDLE;
      end
   end

   logic                  p_cs   [2];
   logic                  p_we   [2];
   logic                  p_oe   [2];
   logic [ADDR_WIDTH-1:0] p_addr [2];
   logic [DATA_WIDTH-1:0] p_din  [2];

   // Port FSM: outputs. RD_DATA with no new read re-issues the previous address.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         p_cs[p]   = 1'b0;
         p_we[p]   = 1'b0;
         p_oe[p]   = 1'b0;
         p_addr[p] = '0;
         p_din[p]  = '0;
         if (port_gnt[p]) begin
            p_cs[p]   = 1'b1;
            p_addr[p] = addr[port_idx[p]];
            if (port_op[p] == OP_WR) begin
               p_we[p]  = 1'b1;
               p_din[p] = wdata[port_idx[p]];
            end else begin
               p_oe[p] = 1'b1;
            end
         end else if (state_q[p] == RD_DATA) begin
            p_cs[p]   = 1'b1;
            p_oe[p]   = 1'b1;
            p_addr[p] = hold_addr_q[p];
         end
      end
   end

   assign ram_cs_0      = p_cs[0];
   assign ram_cs_1      = p_cs[1];
   assign ram_we_0      = p_we[0];
   assign ram_we_1      = p_we[1];
   assign ram_oe_0      = p_oe[0];
   assign ram_oe_1      = p_oe[1];
   assign ram_address_0 = p_addr[0];
   assign ram_address_1 = p_addr[1];
   assign ram_data_in_0 = p_din[0];
   assign ram_data_in_1 = p_din[1];

   logic [DATA_WIDTH-1:0] ram_dout [2];
   assign ram_dout[0] = ram_data_out_0;
   assign ram_dout[1] = ram_data_out_1;

   tag_t                  tag_s1_q [2];
   tag_t                  tag_s2_q [2];
   logic [DATA_WIDTH-1:0] rdata_q  [NUM_REQ];

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         for (int p = 0; p < 2; p++) begin
            tag_s1_q[p] <= '0;
            tag_s2_q[p] <= '0;
         end
         // NOTE: the response registers drive outputs that must read zero in reset, so this array is reset unlike a plain storage memory.
         for (int i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            tag_s1_q[p] <= '{vld: port_gnt[p] && (port_op[p] == OP_RD), idx: TAG_W'(port_idx[p])};
            tag_s2_q[p] <= tag_s1_q[p];
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            for (int p = 0; p < 2; p++) begin
               if (tag_s1_q[p].vld && (tag_s1_q[p].idx == TAG_W'(i))) rdata_q[i] <= ram_dout[p];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = (tag_s2_q[0].vld && (tag_s2_q[0].idx == TAG_W'(i))) ||
                        (tag_s2_q[1].vld && (tag_s2_q[1].idx == TAG_W'(i)));
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
      assign rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH] = rdata_q[g];
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural dual-port RAM attached.
module tb_mem_port_arbiter;

   localparam int NR = 4;
   localparam int DW = 290;
   localparam int AW = 8;

   logic                clk;
   logic                reset_N;
   logic [NR-1:0]       req_valid;
   logic [NR-1:0]       req_we;
   logic [NR*AW-1:0]    req_addr;
   logic [NR*DW-1:0]    req_wdata;
   logic [NR-1:0]       req_ready;
   logic [NR-1:0]       rsp_valid;
   logic [NR*DW-1:0]    rsp_rdata;
   logic [AW-1:0]       ram_address_0, ram_address_1;
   logic [DW-1:0]       ram_data_in_0, ram_data_in_1;
   logic                ram_cs_0, ram_cs_1, ram_we_0, ram_we_1, ram_oe_0, ram_oe_1;
   logic [DW-1:0]       ram_data_out_0, ram_data_out_1;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk            (clk),
      .reset_N        (reset_N),
      .req_valid      (req_valid),
      .req_we         (req_we),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .ram_address_0  (ram_address_0),
      .ram_address_1  (ram_address_1),
      .ram_data_in_0  (ram_data_in_0),
      .ram_data_in_1  (ram_data_in_1),
      .ram_cs_0       (ram_cs_0),
      .ram_cs_1       (ram_cs_1),
      .ram_we_0       (ram_we_0),
      .ram_we_1       (ram_we_1),
      .ram_oe_0       (ram_oe_0),
      .ram_oe_1       (ram_oe_1),
      .ram_data_out_0 (ram_data_out_0),
      .ram_data_out_1 (ram_data_out_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous dual-port RAM: address registered on a read, output gated by cs&&oe&&!we.
   logic [DW-1:0] mem [256];
   logic [AW-1:0] aq0, aq1;

   always @(posedge clk) begin
      if (ram_cs_0 && ram_we_0)  mem[ram_address_0] <= ram_data_in_0;
      if (ram_cs_1 && ram_we_1)  mem[ram_address_1] <= ram_data_in_1;
      if (ram_cs_0 && !ram_we_0) aq0 <= ram_address_0;
      if (ram_cs_1 && !ram_we_1) aq1 <= ram_address_1;
   end

   assign ram_data_out_0 = (ram_cs_0 && ram_oe_0 && !ram_we_0) ? mem[aq0] : '0;
   assign ram_data_out_1 = (ram_cs_1 && ram_oe_1 && !ram_we_1) ? mem[aq1] : '0;

   function automatic logic [DW-1:0] pat(input logic [7:0] b);
      logic [295:0] t;
      t = {37{b}};
      return t[DW-1:0];
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i]          = 1'b1;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic clear_req();
      req_valid = '0;
      req_we    = '0;
   endtask

   initial begin
      reset_N   = 1'b0;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);

      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rdata_zero", |rsp_rdata, 0);
      set_req(0, 1'b0, 8'h10, '0);
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_cs0", ram_cs_0, 0);
      check("rst_cs1", ram_cs_1, 0);
      clear_req();

      // 1: r0 writes 0x10, r1 reads it back
      @(negedge clk);
      reset_N = 1'b1;
      set_req(0, 1'b1, 8'h10, pat(8'hA5));
      #1;
      check("t1_wr_ready", req_ready, 4'b0001);
      check("t1_wr_cs0", ram_cs_0, 1);
      check("t1_wr_we0", ram_we_0, 1);
      check("t1_wr_addr0", ram_address_0, 8'h10);
      check("t1_wr_din0", ram_data_in_0, pat(8'hA5));
      check("t1_wr_cs1", ram_cs_1, 0);
      @(negedge clk);
      clear_req();
      set_req(1, 1'b0, 8'h10, '0);
      #1;
      check("t1_rd_ready", req_ready, 4'b0010);
      check("t1_rd_oe0", ram_oe_0, 1);
      check("t1_rd_we0", ram_we_0, 0);
      @(negedge clk);
      clear_req();
      #1;
      check("t1_hold_cs0", ram_cs_0, 1);
      check("t1_hold_oe0", ram_oe_0, 1);
      check("t1_hold_addr0", ram_address_0, 8'h10);
      check("t1_n1_rsp", rsp_valid, 0);
      @(negedge clk);
      check("t1_n2_rsp", rsp_valid, 4'b0010);
      check("t1_n2_data", rsp_rdata[1*DW +: DW], pat(8'hA5));
      check("t1_n2_cs0", ram_cs_0, 0);
      @(negedge clk);
      check("t1_pulse_end", rsp_valid, 0);
      check("t1_data_held", rsp_rdata[1*DW +: DW], pat(8'hA5));

      // r3 writes 0x20, which also brings rr_ptr back to 0
      set_req(3, 1'b1, 8'h20, pat(8'h3C));
      #1;
      check("pre2_ready", req_ready, 4'b1000);
      @(negedge clk);
      clear_req();

      // 2: all four read continuously
      set_req(0, 1'b0, 8'h10, '0);
      set_req(1, 1'b0, 8'h20, '0);
      set_req(2, 1'b0, 8'h10, '0);
      set_req(3, 1'b0, 8'h20, '0);
      #1;
      check("t2_c0_ready", req_ready, 4'b0011);
      check("t2_c0_both_cs", ram_cs_0 && ram_cs_1, 1);
      @(negedge clk);
      #1;
      check("t2_c1_ready", req_ready, 4'b1100);
      check("t2_c1_rsp", rsp_valid, 0);
      @(negedge clk);
      #1;
      check("t2_c2_ready", req_ready, 4'b0011);
      check("t2_c2_rsp", rsp_valid, 4'b0011);
      check("t2_c2_d0", rsp_rdata[0*DW +: DW], pat(8'hA5));
      check("t2_c2_d1", rsp_rdata[1*DW +: DW], pat(8'h3C));
      @(negedge clk);
      #1;
      check("t2_c3_ready", req_ready, 4'b1100);
      check("t2_c3_rsp", rsp_valid, 4'b1100);
      check("t2_c3_d2", rsp_rdata[2*DW +: DW], pat(8'hA5));
      check("t2_c3_d3", rsp_rdata[3*DW +: DW], pat(8'h3C));
      @(negedge clk);
      clear_req();
      check("t2_c4_rsp", rsp_valid, 4'b0011);
      @(negedge clk);
      check("t2_c5_rsp", rsp_valid, 4'b1100);
      @(negedge clk);
      check("t2_c6_rsp", rsp_valid, 0);

      // 3: W/W collision on 0x33
      set_req(0, 1'b1, 8'h33, pat(8'h11));
      set_req(2, 1'b1, 8'h33, pat(8'h22));
      #1;
      check("t3_c0_ready", req_ready, 4'b0001);
      @(negedge clk);
      req_valid[0] = 1'b0;
      #1;
      check("t3_c1_ready", req_ready, 4'b0100);
      @(negedge clk);
      clear_req();
      set_req(1, 1'b0, 8'h33, '0);
      #1;
      check("t3_rd_ready", req_ready, 4'b0010);
      @(negedge clk);
      clear_req();
      @(negedge clk);
      check("t3_rsp", rsp_valid, 4'b0010);
      check("t3_final_data", rsp_rdata[1*DW +: DW], pat(8'h22));

      // 4: R/W collision on 0x40; rr_ptr=2 so r3's write wins
      set_req(1, 1'b0, 8'h40, '0);
      set_req(3, 1'b1, 8'h40, pat(8'h44));
      #1;
      check("t4_c0_ready", req_ready, 4'b1000);
      @(negedge clk);
      req_valid[3] = 1'b0;
      #1;
      check("t4_c1_ready", req_ready, 4'b0010);
      @(negedge clk);
      clear_req();
      @(negedge clk);
      check("t4_rsp", rsp_valid, 4'b0010);
      check("t4_data", rsp_rdata[1*DW +: DW], pat(8'h44));

      // 5: write steered to port 1 while port 0 holds a read
      set_req(2, 1'b0, 8'h33, '0);
      #1;
      check("t5_rd_ready", req_ready, 4'b0100);
      @(negedge clk);
      clear_req();
      set_req(0, 1'b1, 8'h50, pat(8'h55));
      #1;
      check("t5_wr_ready", req_ready, 4'b0001);
      check("t5_wr_cs1", ram_cs_1, 1);
      check("t5_wr_we1", ram_we_1, 1);
      check("t5_wr_addr1", ram_address_1, 8'h50);
      check("t5_wr_din1", ram_data_in_1, pat(8'h55));
      check("t5_hold_cs0", ram_cs_0, 1);
      check("t5_hold_oe0", ram_oe_0, 1);
      check("t5_hold_we0", ram_we_0, 0);
      check("t5_hold_addr0", ram_address_0, 8'h33);
      @(negedge clk);
      clear_req();
      check("t5_rsp", rsp_valid, 4'b0100);
      check("t5_data", rsp_rdata[2*DW +: DW], pat(8'h22));
      set_req(1, 1'b0, 8'h50, '0);
      #1;
      check("t5_rb_ready", req_ready, 4'b0010);
      @(negedge clk);
      clear_req();
      @(negedge clk);
      check("t5_rb_rsp", rsp_valid, 4'b0010);
      check("t5_rb_data", rsp_rdata[1*DW +: DW], pat(8'h55));

      // 6: reset one cycle after a read grant
      set_req(1, 1'b0, 8'h10, '0);
      #1;
      check("t6_ready", req_ready, 4'b0010);
      @(negedge clk);
      clear_req();
      reset_N = 1'b0;
      #1;
      check("t6_rst_rsp", rsp_valid, 0);
      check("t6_rst_cs0", ram_cs_0, 0);
      check("t6_rst_oe0", ram_oe_0, 0);
      check("t6_rst_rdata", |rsp_rdata, 0);
      @(negedge clk);
      check("t6_rst_rsp_n2", rsp_valid, 0);
      @(negedge clk);
      check("t6_rst_rsp_n3", rsp_valid, 0);
      reset_N = 1'b1;
      set_req(0, 1'b0, 8'h10, '0);
      set_req(2, 1'b0, 8'h20, '0);
      set_req(3, 1'b0, 8'h20, '0);
      #1;
      check("t6_post_ready", req_ready, 4'b0101);
      @(negedge clk);
      clear_req();
      @(negedge clk);
      check("t6_post_rsp", rsp_valid, 4'b0101);
      check("t6_post_d0", rsp_rdata[0*DW +: DW], pat(8'hA5));
      check("t6_post_d2", rsp_rdata[2*DW +: DW], pat(8'h3C));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
